// File: rtl/rns_pkg.sv
// Shared definitions for the {2^N+1, 2^N, 2^N-1} residue number system converters.
package rns_pkg;

   localparam int unsigned RNS_N = 30;
   localparam int unsigned W1    = RNS_N + 1;
   localparam int unsigned W2    = RNS_N;
   localparam int unsigned W3    = RNS_N;
   localparam int unsigned WIN   = 3 * RNS_N;

   localparam logic [W1-1:0] MOD1 = {1'b1, {(RNS_N-1){1'b0}}, 1'b1};
   localparam logic [W3-1:0] MOD3 = {W3{1'b1}};

   typedef struct packed {
      logic [W1-1:0] x1;
      logic [W2-1:0] x2;
      logic [W3-1:0] x3;
   } rns_triple_t;

endpackage

// File: rtl/mod_2n_m1_add.sv
// W-bit modulo (2^W-1) adder using end-around carry; the all-ones alias of zero
// is folded to canonical 0 on the output.
module mod_2n_m1_add #(
   parameter int unsigned W = 30
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_sum_c
);

   logic [W:0]   w_raw;
   logic [W-1:0] w_eac;

   // Operands are at most 2^W-1, so the end-around add cannot carry again.
   assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
   assign w_eac   = w_raw[W-1:0] + W'(w_raw[W]);
   assign o_sum_c = (w_eac == {W{1'b1}}) ? '0 : w_eac;

endmodule

// File: rtl/rns_forward_converter_pipe.sv
// Two-stage binary-to-RNS forward converter for moduli {2^N+1, 2^N, 2^N-1}
// with valid/ready handshaking on both sides.
module rns_forward_converter_pipe
   import rns_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic [WIN-1:0] in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [W1-1:0]  x1,
   output logic [W2-1:0]  x2,
   output logic [W3-1:0]  x3,
   output logic           out_valid,
   input  logic           out_ready
);

   localparam int unsigned N = RNS_N;
   localparam logic [N+1:0] MOD1_EXT = {1'b0, MOD1};

   logic          w_en;
   logic [N-1:0]  w_a;
   logic [N-1:0]  w_b;
   logic [N-1:0]  w_c;

   logic          r_v1;
   logic [N-1:0]  r_c1;
   logic [N:0]    r_s1;
   logic [N:0]    r_p1;
   logic [N-1:0]  r_b1;

   logic [N-1:0]  w_s1_fold;
   logic [N-1:0]  w_x3;
   logic [N+1:0]  w_diff;
   logic [W1-1:0] w_x1;

   rns_triple_t   r_out;
   logic          r_out_valid;

   assign w_en     = ~r_out_valid | out_ready;
   assign in_ready = w_en;

   assign w_a = in_data[3*N-1:2*N];
   assign w_b = in_data[2*N-1:N];
   assign w_c = in_data[N-1:0];

   // Stage 1: partial sums for the mod 2^N-1 and mod 2^N+1 channels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_c1 <= '0;
         r_s1 <= '0;
         r_p1 <= '0;
         r_b1 <= '0;
      end else if (w_en) begin
         r_v1 <= in_valid;
         r_c1 <= w_c;
         r_s1 <= {1'b0, w_a} + {1'b0, w_b};
         r_p1 <= {1'b0, w_a} + {1'b0, w_c};
         r_b1 <= w_b;
      end
   end

   // Fold the (N+1)-bit A+B into N bits before the end-around add with C.
   assign w_s1_fold = r_s1[N-1:0] + N'(r_s1[N]);

   mod_2n_m1_add #(.W(N)) u_x3_add (
      .i_a     (w_s1_fold),
      .i_b     (r_c1),
      .o_sum_c (w_x3)
   );

   // Since 2^N = -1 mod 2^N+1, X reduces to A - B + C; one correction suffices.
   assign w_diff = {1'b0, r_p1} - {2'b00, r_b1};

   always_comb begin
      w_x1 = w_diff[N:0];
      if (w_diff[N+1]) begin
         w_x1 = W1'(w_diff + MOD1_EXT);
      end else if (w_diff >= MOD1_EXT) begin
         w_x1 = W1'(w_diff - MOD1_EXT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_en) begin
         r_out_valid <= r_v1;
         r_out.x1    <= w_x1;
         r_out.x2    <= r_c1;
         r_out.x3    <= w_x3;
      end
   end

   assign x1        = r_out.x1;
   assign x2        = r_out.x2;
   assign x3        = r_out.x3;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rns_forward_converter_pipe.sv
// Self-checking bench: directed residues, backpressure, mid-flight reset and a
// long random stream scored against plain modulo arithmetic.
module tb_rns_forward_converter_pipe;
   import rns_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic [WIN-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   logic [W1-1:0]  x1;
   logic [W2-1:0]  x2;
   logic [W3-1:0]  x3;
   logic           out_valid;
   logic           out_ready;

   int             n_cmp = 0;
   int             n_err = 0;
   int             n_out = 0;
   rns_triple_t    sb[$];
   logic [WIN-1:0] w[4];

   always #5 clk = ~clk;

   rns_forward_converter_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic rns_triple_t ref_conv(input logic [WIN-1:0] x);
      rns_triple_t t;
      logic [WIN-1:0] m1, m2, m3;
      m1 = WIN'(MOD1);
      m2 = WIN'(1) << RNS_N;
      m3 = WIN'(MOD3);
      t.x1 = W1'(x % m1);
      t.x2 = W2'(x % m2);
      t.x3 = W3'(x % m3);
      return t;
   endfunction

   function automatic logic [WIN-1:0] rand_x();
      return WIN'({$urandom, $urandom, $urandom});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expectations enter on input transfer, leave on output transfer.
   always @(negedge clk) begin
      rns_triple_t e;
      if (!rst && out_valid && out_ready) begin
         check_eq("sb_has_entry", 96'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("sb_x1", x1, e.x1);
            check_eq("sb_x2", x2, e.x2);
            check_eq("sb_x3", x3, e.x3);
         end
         check_eq("x3_not_all_ones", 96'(x3 != MOD3), 1);
         n_out++;
      end
      if (!rst && in_valid && in_ready) sb.push_back(ref_conv(in_data));
   end

   task automatic directed(input string tag, input logic [WIN-1:0] x,
                           input logic [W1-1:0] e1, input logic [W2-1:0] e2,
                           input logic [W3-1:0] e3);
      in_valid = 1'b1;
      in_data  = x;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check_eq({tag, "_early"}, out_valid, 0);
      step();
      check_eq({tag, "_valid"}, out_valid, 1);
      check_eq({tag, "_x1"}, x1, e1);
      check_eq({tag, "_x2"}, x2, e2);
      check_eq({tag, "_x3"}, x3, e3);
      step();
      check_eq({tag, "_one_cycle"}, out_valid, 0);
   endtask

   initial begin
      int             idx;
      int             stall;
      int             base;
      logic           stall_done;
      logic           xfer;
      logic [90:0]    snap;
      logic [WIN-1:0] xr;
      rns_triple_t    er;

      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      step();
      step();
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_x1", x1, 0);
      check_eq("rst_x2", x2, 0);
      check_eq("rst_x3", x3, 0);
      check_eq("rst_in_ready", in_ready, 1);
      #1 rst = 1'b0;
      step();

      directed("zero", '0, 0, 0, 0);
      directed("p30", WIN'(1) << 30, 31'd1073741824, 30'd0, 30'd1);
      directed("p30m1", (WIN'(1) << 30) - WIN'(1), 31'd1073741823, 30'd1073741823, 30'd0);
      directed("five_p30", WIN'(5) << 30, 31'd1073741820, 30'd0, 30'd5);
      directed("p60", WIN'(1) << 60, 31'd1, 30'd0, 30'd1);
      directed("p90m1", {WIN{1'b1}}, 31'd1073741823, 30'd1073741823, 30'd0);
      directed("x1_over", ((WIN'(1) << 30) - WIN'(1)) * ((WIN'(1) << 60) + WIN'(1)),
               31'd1073741821, 30'd1073741823, 30'd0);

      // Backpressure: four words, output stalled for three cycles.
      for (int i = 0; i < 4; i++) w[i] = rand_x();
      idx = 0;
      stall = 0;
      stall_done = 1'b0;
      snap = '0;
      base = n_out;
      for (int cyc = 0; cyc < 60 && n_out < base + 4; cyc++) begin
         in_valid = (idx < 4);
         in_data  = (idx < 4) ? w[idx] : '0;
         if (!stall_done && out_valid) begin
            stall = 3;
            stall_done = 1'b1;
            snap = {x1, x2, x3};
         end
         out_ready = (stall == 0);
         #1;
         if (stall > 0) begin
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_stable", {x1, x2, x3}, snap);
            stall--;
         end
         xfer = in_valid && in_ready;
         step();
         if (xfer) idx++;
      end
      check_eq("bp_accepted", idx, 4);
      check_eq("bp_delivered", n_out - base, 4);
      check_eq("bp_stalled", stall_done, 1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();

      // Reset with two words in flight.
      in_valid = 1'b1;
      in_data = rand_x();
      step();
      in_data = rand_x();
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check_eq("mid_pre_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", out_valid, 0);
      check_eq("mid_rst_x", {x1, x2, x3}, 0);
      sb.delete();
      step();
      #2 rst = 1'b0;
      step();
      xr = rand_x();
      er = ref_conv(xr);
      directed("post_rst", xr, er.x1, er.x2, er.x3);

      // Random stream with random backpressure.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_x();
         out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) step();
      check_eq("drain_empty", 96'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
